// File: rtl/ws2812b_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_pixel_feeder
// Description : FIFO-buffered {R,G,B} -> {G,R,B} pixel feeder with per-frame
//               latch holdoff. Optional scaling enabled by WS2812B_BRIGHTNESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_pixel_feeder #(
  parameter int DEPTH          = 16,
  parameter int NUM_LEDS       = 64,
  parameter int HOLDOFF_CYCLES = 500,
  parameter int HOLD_W         = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [23:0]              wr_data,
  output logic                     wr_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  input  logic [7:0]               brightness,
  output logic                     bitstream_available,
  output logic [23:0]              bitstream,
  input  logic                     bitstream_read,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clear_errors
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(NUM_LEDS + 1);

  localparam logic [0:0] ST_STREAM  = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  logic [23:0]       r_mem [DEPTH];
  logic [LW-1:0]     r_wr_ptr;
  logic [LW-1:0]     r_rd_ptr;
  logic              r_wr_full;
  logic [LW-1:0]     r_fifo_level;
  logic              r_head_valid;
  logic [23:0]       r_bitstream;
  logic [CW-1:0]     r_pix_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [0:0]        r_state;
  logic              r_frame_done;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_avail;
  logic              w_wr_acc;
  logic              w_consume;
  logic              w_empty;
  logic              w_pop;
  logic [LW-1:0]     w_wr_ptr_nx;
  logic [LW-1:0]     w_rd_ptr_nx;
  logic [23:0]       w_raw;
  logic [23:0]       w_fmt;
  logic              w_last_pixel;

`ifdef WS2812B_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  assign w_fmt = {scale(w_raw[15:8], brightness),
                  scale(w_raw[23:16], brightness),
                  scale(w_raw[7:0], brightness)};
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_fmt = {w_raw[15:8], w_raw[23:16], w_raw[7:0]};
`endif

  assign w_avail      = r_head_valid && (r_state == ST_STREAM);
  // Full is sampled before the pop, so a write while full is lost even if a pop happens.
  assign w_wr_acc     = wr_en && !r_wr_full;
  assign w_consume    = bitstream_read && w_avail;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_pop        = !w_empty && (!r_head_valid || w_consume);
  assign w_wr_ptr_nx  = r_wr_ptr + LW'(w_wr_acc);
  assign w_rd_ptr_nx  = r_rd_ptr + LW'(w_pop);
  assign w_raw        = r_mem[r_rd_ptr[AW-1:0]];
  assign w_last_pixel = (r_pix_cnt == CW'(NUM_LEDS - 1));

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_wr_full    <= 1'b0;
      r_fifo_level <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nx;
      r_rd_ptr     <= w_rd_ptr_nx;
      r_wr_full    <= (w_wr_ptr_nx[AW] != w_rd_ptr_nx[AW]) &&
                      (w_wr_ptr_nx[AW-1:0] == w_rd_ptr_nx[AW-1:0]);
      r_fifo_level <= w_wr_ptr_nx - w_rd_ptr_nx;
    end
  end

  // Head register: a consume with data behind it reloads on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head_valid <= 1'b0;
      r_bitstream  <= '0;
    end else if (w_pop) begin
      r_head_valid <= 1'b1;
      r_bitstream  <= w_fmt;
    end else if (w_consume) begin
      r_head_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_STREAM;
      r_pix_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_STREAM: begin
          if (w_consume) begin
            if (w_last_pixel) begin
              r_pix_cnt    <= '0;
              r_frame_done <= 1'b1;
              r_hold_cnt   <= HOLD_W'(HOLDOFF_CYCLES - 1);
              r_state      <= ST_HOLDOFF;
            end else begin
              r_pix_cnt <= r_pix_cnt + CW'(1);
            end
          end
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == '0) begin
            r_state <= ST_STREAM;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: r_state <= ST_STREAM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_errors) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_wr_full) begin
        r_overflow <= 1'b1;
      end
      if (bitstream_read && !w_avail) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign wr_full             = r_wr_full;
  assign fifo_level          = r_fifo_level;
  assign bitstream_available = w_avail;
  assign bitstream           = r_bitstream;
  assign frame_done          = r_frame_done;
  assign overflow            = r_overflow;
  assign underflow           = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812b_pixel_feeder
// Description : Directed scoreboard bench for ws2812b_pixel_feeder (NUM_LEDS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812b_pixel_feeder;

  localparam int DEPTH    = 16;
  localparam int NUM_LEDS = 4;
  localparam int HOLDOFF  = 500;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        wr_full;
  logic [4:0]  fifo_level;
  logic [7:0]  brightness;
  logic        bitstream_available;
  logic [23:0] bitstream;
  logic        bitstream_read;
  logic        frame_done;
  logic        overflow;
  logic        underflow;
  logic        clear_errors;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [23:0] sb[$];

  ws2812b_pixel_feeder #(
    .DEPTH(DEPTH), .NUM_LEDS(NUM_LEDS), .HOLDOFF_CYCLES(HOLDOFF), .HOLD_W(10)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .fifo_level(fifo_level), .brightness(brightness),
    .bitstream_available(bitstream_available), .bitstream(bitstream),
    .bitstream_read(bitstream_read), .frame_done(frame_done),
    .overflow(overflow), .underflow(underflow), .clear_errors(clear_errors)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
`ifdef WS2812B_BRIGHTNESS_EN
    return 8'((int'(c) * (int'(b) + 1)) / 256);
`else
    return c;
`endif
  endfunction

  function automatic logic [23:0] fmt(input logic [23:0] p, input logic [7:0] b);
    return {sc(p[15:8], b), sc(p[23:16], b), sc(p[7:0], b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_px(input logic [23:0] p);
    wr_en   = 1'b1;
    wr_data = p;
    sb.push_back(fmt(p, brightness));
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic exp_fd);
    logic [23:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
    check({tag, "_avail"}, 32'(bitstream_available), 32'd1);
    check({tag, "_data"}, 32'(bitstream), 32'(e));
    bitstream_read = 1'b1;
    tick();
    bitstream_read = 1'b0;
    check({tag, "_frame_done"}, 32'(frame_done), 32'(exp_fd));
  endtask

  initial begin
    int hi;
    logic [23:0] lit;
    resetn = 1'b0; wr_en = 1'b0; wr_data = '0; brightness = 8'd127;
    bitstream_read = 1'b0; clear_errors = 1'b0;
    repeat (3) tick();
    check("rst_avail", 32'(bitstream_available), 32'd0);
    check("rst_bitstream", 32'(bitstream), 32'd0);
    check("rst_full", 32'(wr_full), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_flags", {29'd0, frame_done, overflow, underflow}, 32'd0);
    resetn = 1'b1;
    tick();

    // read pulse with nothing presented
    bitstream_read = 1'b1;
    tick();
    bitstream_read = 1'b0;
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_no_frame", 32'(frame_done), 32'd0);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("uf_clear", 32'(underflow), 32'd0);

    write_px(24'h112233);
    check("lat_avail_1", 32'(bitstream_available), 32'd0);
    check("lat_level", 32'(fifo_level), 32'd1);
    tick();
    check("lat_avail_2", 32'(bitstream_available), 32'd1);
    check("first_data", 32'(bitstream), 32'(sb[0]));
`ifndef WS2812B_BRIGHTNESS_EN
    check("first_literal", 32'(bitstream), 32'h221133);
`endif

    for (int i = 1; i <= 5; i++) write_px({8'(i), 8'(i + 16), 8'(i + 32)});
    for (int r = 0; r < NUM_LEDS; r++) do_read($sformatf("frm_rd%0d", r), r == NUM_LEDS - 1);

    hi = 0;
    for (int k = 0; k < HOLDOFF; k++) begin
      if (bitstream_available) hi++;
      if (k < HOLDOFF - 1) tick();
      if (k == 0) check("fd_one_cycle", 32'(frame_done), 32'd0);
    end
    check("holdoff_low", 32'(hi), 32'd0);
    tick();
    check("holdoff_exit_avail", 32'(bitstream_available), 32'd1);
    check("pixel5_data", 32'(bitstream), 32'(sb[0]));
    do_read("px5", 1'b0);
    do_read("px6", 1'b0);
    check("drained_avail", 32'(bitstream_available), 32'd0);

    write_px(24'hFF8002);
    tick();
`ifdef WS2812B_BRIGHTNESS_EN
    lit = 24'h407F01;
`else
    lit = 24'h80FF02;
`endif
    check("bright_literal", 32'(bitstream), 32'(lit));
    do_read("bright_rd", 1'b0);

    // head loads the first write, so DEPTH+1 fit and the last is dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en   = 1'b1;
      wr_data = {8'hA0, 8'(i), 8'(i * 3)};
      if (i <= DEPTH) sb.push_back(fmt(wr_data, brightness));
      tick();
    end
    wr_en = 1'b0;
    check("ovf_full", 32'(wr_full), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'(DEPTH));
    check("ovf_set", 32'(overflow), 32'd1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    do_read("ovf_rd", 1'b1);
    check("hold_level", 32'(fifo_level), 32'(DEPTH - 1));
    repeat (10) tick();
    check("hold_avail", 32'(bitstream_available), 32'd0);

    #2 resetn = 1'b0;
    #1;
    check("arst_avail", 32'(bitstream_available), 32'd0);
    check("arst_bitstream", 32'(bitstream), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_flags", {28'd0, wr_full, frame_done, overflow, underflow}, 32'd0);
    sb.delete();
    tick();
    tick();
    resetn = 1'b1;
    tick();

    write_px(24'h0A0B0C);
    check("post_lat_1", 32'(bitstream_available), 32'd0);
    write_px(24'h1A1B1C);
    check("post_lat_2", 32'(bitstream_available), 32'd1);
    check("post_px0", 32'(bitstream), 32'(sb[0]));
    write_px(24'h2A2B2C);
    write_px(24'h3A3B3C);
    for (int r = 0; r < NUM_LEDS; r++) do_read($sformatf("new_rd%0d", r), r == NUM_LEDS - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
